// File: rtl/matmul_stream_engine.sv
// Streaming matrix multiplier: takes an M,K,N header and A/B element streams, then emits
// C = A*B row-major. The datapath performs one multiply-accumulate per clock.
module matmul_stream_engine #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_DIM = 4,
  parameter int unsigned ACC_W   = 18,
  parameter int unsigned SIGNED  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [DATA_W-1:0] DimMax = DATA_W'(MAX_DIM);

  typedef enum logic [2:0] {
    StIdle, StHdrK, StHdrN, StLoadA, StLoadB, StCompute, StSend
  } state_e;

  state_e state_q;

  logic [DATA_W-1:0] a_mem [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] b_mem [MAX_DIM][MAX_DIM];
  logic [ACC_W-1:0]  c_mem [MAX_DIM][MAX_DIM];

  logic [DATA_W-1:0] dim_m_q, dim_k_q;
  logic [IW-1:0]     m_last_q, k_last_q, n_last_q;
  logic [IW-1:0]     i_q, j_q, k_q;
  logic [ACC_W-1:0]  acc_q;

  logic              in_hs;
  logic [DATA_W-1:0] a_op, b_op;
  logic [ACC_W-1:0]  a_ext, b_ext, prod, sum;
  logic [IW-1:0]     ni, nj;

  function automatic logic dim_bad(input logic [DATA_W-1:0] d);
    return (d == '0) || (d > DimMax);
  endfunction

  assign in_hs = in_valid & in_ready;

  always_comb begin
    a_op  = a_mem[i_q][k_q];
    b_op  = b_mem[k_q][j_q];
    // Operands extended to ACC_W so the truncated product is exact modulo 2^ACC_W.
    a_ext = {{(ACC_W - DATA_W){(SIGNED != 0) & a_op[DATA_W-1]}}, a_op};
    b_ext = {{(ACC_W - DATA_W){(SIGNED != 0) & b_op[DATA_W-1]}}, b_op};
    prod  = a_ext * b_ext;
    sum   = ((k_q == '0) ? '0 : acc_q) + prod;
    nj    = (j_q == n_last_q) ? '0 : j_q + 1'b1;
    ni    = (j_q == n_last_q) ? i_q + 1'b1 : i_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dim_m_q   <= '0;
      dim_k_q   <= '0;
      m_last_q  <= '0;
      k_last_q  <= '0;
      n_last_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      for (int unsigned r = 0; r < MAX_DIM; r++) begin
        for (int unsigned c = 0; c < MAX_DIM; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
          c_mem[r][c] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_hs) begin
            dim_m_q <= in_data;
            busy    <= 1'b1;
            state_q <= StHdrK;
          end
        end
        StHdrK: begin
          if (in_hs) begin
            dim_k_q <= in_data;
            state_q <= StHdrN;
          end
        end
        StHdrN: begin
          if (in_hs) begin
            if (dim_bad(dim_m_q) || dim_bad(dim_k_q) || dim_bad(in_data)) begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              m_last_q <= IW'(dim_m_q - 1'b1);
              k_last_q <= IW'(dim_k_q - 1'b1);
              n_last_q <= IW'(in_data - 1'b1);
              i_q      <= '0;
              j_q      <= '0;
              state_q  <= StLoadA;
            end
          end
        end
        StLoadA: begin
          if (in_hs) begin
            a_mem[i_q][j_q] <= in_data;
            if (j_q == k_last_q) begin
              j_q <= '0;
              if (i_q == m_last_q) begin
                i_q     <= '0;
                state_q <= StLoadB;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (in_hs) begin
            b_mem[i_q][j_q] <= in_data;
            if (j_q == n_last_q) begin
              j_q <= '0;
              if (i_q == k_last_q) begin
                i_q      <= '0;
                k_q      <= '0;
                in_ready <= 1'b0;
                state_q  <= StCompute;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        StCompute: begin
          acc_q <= sum;
          if (k_q == k_last_q) begin
            c_mem[i_q][j_q] <= sum;
            k_q <= '0;
            if (j_q == n_last_q) begin
              j_q <= '0;
              if (i_q == m_last_q) begin
                i_q       <= '0;
                out_valid <= 1'b1;
                // A 1x1 result has C[0][0] only in flight, not yet in c_mem.
                out_data  <= (m_last_q == '0 && n_last_q == '0) ? sum : c_mem[0][0];
                out_last  <= (m_last_q == '0 && n_last_q == '0);
                state_q   <= StSend;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state_q   <= StIdle;
            end else begin
              i_q      <= ni;
              j_q      <= nj;
              out_data <= c_mem[ni][nj];
              out_last <= (ni == m_last_q) && (nj == n_last_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
